// File: rtl/spi_burst_master_if.sv
// Bundles the host-side FIFO/command signals and the downstream byte-controller
// handshake of spi_burst_master. The master modport is the block's own view.
interface spi_burst_master_if #(
    parameter int LEN_W = 4
);
    logic             tx_wr_en;
    logic [7:0]       tx_wr_data;
    logic             tx_full;
    logic [LEN_W:0]   tx_count;

    logic             cmd_valid;
    logic [LEN_W-1:0] cmd_len;
    logic             cmd_err;
    logic             burst_busy;
    logic             burst_done;

    logic             rx_rd_en;
    logic [7:0]       rx_rd_data;
    logic             rx_empty;
    logic             rx_overflow;

    logic             ctl_start;
    logic [7:0]       ctl_data;
    logic             ctl_hold_cs;
    logic             ctl_busy;
    logic             ctl_done;
    logic [7:0]       ctl_rx_data;

    modport master (
        input  tx_wr_en, tx_wr_data, cmd_valid, cmd_len, rx_rd_en,
               ctl_busy, ctl_done, ctl_rx_data,
        output tx_full, tx_count, cmd_err, burst_busy, burst_done,
               rx_rd_data, rx_empty, rx_overflow,
               ctl_start, ctl_data, ctl_hold_cs
    );

    modport slave (
        output tx_wr_en, tx_wr_data, cmd_valid, cmd_len, rx_rd_en,
               ctl_busy, ctl_done, ctl_rx_data,
        input  tx_full, tx_count, cmd_err, burst_busy, burst_done,
               rx_rd_data, rx_empty, rx_overflow,
               ctl_start, ctl_data, ctl_hold_cs
    );
endinterface

// File: rtl/spi_burst_master.sv
// Burst sequencer in front of a byte-level SPI controller: drains a TX FIFO into
// one chip-select-held transfer and collects the returned bytes in an RX FIFO.
module spi_burst_master #(
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_W      = 4
) (
    input logic                clk,
    input logic                rst,
    spi_burst_master_if.master bus
);

    localparam int             PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [LEN_W:0] DEPTH_C = (LEN_W+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        XFER,
        FINISH
    } state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic             cmd_err_q, cmd_err_d;
    logic             hold_cs_q, hold_cs_d;
    logic             rx_ovf_q, rx_ovf_d;

    logic [7:0]       tx_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] tx_wr_ptr_q, tx_rd_ptr_q;
    logic [LEN_W:0]   tx_count_q, tx_count_d;

    logic [7:0]       rx_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rx_wr_ptr_q, rx_rd_ptr_q;
    logic [LEN_W:0]   rx_count_q, rx_count_d;

    logic [LEN_W:0]   cmd_len_ext;
    logic             cmd_ok, cmd_accept, cmd_reject, byte_done;
    logic             tx_full, tx_push, tx_pop;
    logic             rx_full, rx_empty, rx_push, rx_pop;

    assign cmd_len_ext = {1'b0, bus.cmd_len};
    assign cmd_ok      = (cmd_len_ext != '0) && (cmd_len_ext <= DEPTH_C) &&
                         (tx_count_q >= cmd_len_ext);
    assign cmd_accept  = (state_q == IDLE) && bus.cmd_valid && cmd_ok;
    assign cmd_reject  = (state_q == IDLE) && bus.cmd_valid && !cmd_ok;
    assign byte_done   = (state_q == XFER) && bus.ctl_done;

    // A full FIFO still takes a push in the same cycle as a legal pop.
    assign tx_full  = (tx_count_q == DEPTH_C);
    assign tx_pop   = byte_done && (tx_count_q != '0);
    assign tx_push  = bus.tx_wr_en && (!tx_full || tx_pop);

    assign rx_full  = (rx_count_q == DEPTH_C);
    assign rx_empty = (rx_count_q == '0);
    assign rx_pop   = bus.rx_rd_en && !rx_empty;
    assign rx_push  = byte_done && (!rx_full || rx_pop);

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        tx_count_d  = tx_count_q;
        rx_count_d  = rx_count_q;
        remaining_d = remaining_q;

        if (tx_push && !tx_pop)      tx_count_d = tx_count_q + 1'b1;
        else if (!tx_push && tx_pop) tx_count_d = tx_count_q - 1'b1;

        if (rx_push && !rx_pop)      rx_count_d = rx_count_q + 1'b1;
        else if (!rx_push && rx_pop) rx_count_d = rx_count_q - 1'b1;

        if (cmd_accept)     remaining_d = bus.cmd_len;
        else if (byte_done) remaining_d = remaining_q - 1'b1;

        cmd_err_d = cmd_reject;
        hold_cs_d = (remaining_d > LEN_W'(1));
        rx_ovf_d  = rx_ovf_q | (byte_done && !rx_push);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments only.
        if (!rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            cmd_err_q   <= 1'b0;
            hold_cs_q   <= 1'b0;
            rx_ovf_q    <= 1'b0;
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_count_q  <= '0;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            cmd_err_q   <= cmd_err_d;
            hold_cs_q   <= hold_cs_d;
            rx_ovf_q    <= rx_ovf_d;
            tx_count_q  <= tx_count_d;
            rx_count_q  <= rx_count_d;
            if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + 1'b1;
            if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + 1'b1;
            if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + 1'b1;
            if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + 1'b1;
        end
    end

    // NOTE: FIFO storage is not reset; the zero-count gating on the read ports hides stale bytes.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wr_ptr_q] <= bus.tx_wr_data;
        if (rx_push) rx_mem_q[rx_wr_ptr_q] <= bus.ctl_rx_data;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (cmd_accept) state_d = LAUNCH;
            LAUNCH:    state_d = WAIT_BUSY;
            WAIT_BUSY: if (bus.ctl_busy) state_d = XFER;
            XFER:      if (byte_done && (remaining_q == LEN_W'(1))) state_d = FINISH;
            FINISH:    if (!bus.ctl_busy) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ctl_start  = 1'b0;
        bus.burst_busy = 1'b1;
        bus.burst_done = 1'b0;
        unique case (state_q)
            IDLE:    bus.burst_busy = 1'b0;
            LAUNCH:  bus.ctl_start  = 1'b1;
            FINISH:  bus.burst_done = !bus.ctl_busy;
            default: ;
        endcase
    end

    assign bus.tx_full     = tx_full;
    assign bus.tx_count    = tx_count_q;
    assign bus.cmd_err     = cmd_err_q;
    assign bus.ctl_hold_cs = hold_cs_q;
    assign bus.rx_overflow = rx_ovf_q;
    assign bus.rx_empty    = rx_empty;
    assign bus.ctl_data    = (tx_count_q == '0) ? 8'h00 : tx_mem_q[tx_rd_ptr_q];
    assign bus.rx_rd_data  = rx_empty ? 8'h00 : rx_mem_q[rx_rd_ptr_q];

endmodule

// File: tb/tb_spi_burst_master.sv
// Scoreboard bench for spi_burst_master: queue-based reference of both FIFOs, a
// loop-back controller stub, and a negedge monitor that checks every DUT event.
module tb_spi_burst_master;

    localparam int DEPTH = 8;
    localparam int LW    = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_burst_master_if #(.LEN_W(LW)) bus ();

    spi_burst_master #(.FIFO_DEPTH(DEPTH), .LEN_W(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: FIFO contents as queues, plus expected event queues.
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] exp_tx_q[$];
    bit         exp_hold_q[$];
    int         exp_err_q[$];
    bit         ovf_m = 1'b0;
    int         exp_done_issued = 0;
    int         exp_starts = 0;
    int         done_seen = 0;
    int         n_start = 0;
    int         n_bytes = 0;
    bit         ctl_abort = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Controller stub: one start, then bytes looped back until hold_cs drops.
    initial begin : ctl_model
        int phase;
        int cnt;
        phase = 0;
        cnt   = 0;
        bus.ctl_busy    = 1'b0;
        bus.ctl_done    = 1'b0;
        bus.ctl_rx_data = 8'h00;
        forever begin
            tick();
            bus.ctl_done = 1'b0;
            if (ctl_abort || !rst) begin
                bus.ctl_busy = 1'b0;
                phase = 0;
            end else begin
                case (phase)
                    0: if (bus.ctl_start) begin
                        cnt   = int'($urandom_range(1, 3));
                        phase = 1;
                    end
                    1: begin
                        cnt--;
                        if (cnt == 0) begin
                            bus.ctl_busy = 1'b1;
                            cnt   = int'($urandom_range(1, 3));
                            phase = 2;
                        end
                    end
                    2: begin
                        cnt--;
                        if (cnt == 0) begin
                            if (exp_tx_q.size() == 0) begin
                                check("ctl_unexpected_byte", 32'(bus.ctl_data), 32'h0);
                                check("ctl_unexpected_byte_flag", 32'd1, 32'(exp_tx_q.size()));
                            end else begin
                                check("ctl_data", 32'(bus.ctl_data), 32'(exp_tx_q.pop_front()));
                                check("ctl_hold_cs", 32'(bus.ctl_hold_cs), 32'(exp_hold_q.pop_front()));
                            end
                            bus.ctl_done    = 1'b1;
                            bus.ctl_rx_data = bus.ctl_data;
                            n_bytes++;
                            cnt = int'($urandom_range(1, 3));
                            if (!bus.ctl_hold_cs) phase = 3;
                        end
                    end
                    default: begin
                        cnt--;
                        if (cnt == 0) begin
                            bus.ctl_busy = 1'b0;
                            phase = 0;
                        end
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (bus.ctl_start) n_start++;
            if (bus.cmd_err) begin
                if (exp_err_q.size() == 0) check("cmd_err_unexpected", 32'd1, 32'd0);
                else check("cmd_err_cycle", 32'(cyc), 32'(exp_err_q.pop_front()));
            end
            if (bus.burst_done) begin
                done_seen++;
                check("burst_done_expected", 32'(done_seen <= exp_done_issued), 32'd1);
            end
            if (bus.rx_rd_en) begin
                if (rx_q.size() > 0) begin
                    check("rx_not_empty", 32'(bus.rx_empty), 32'd0);
                    check("rx_rd_data", 32'(bus.rx_rd_data), 32'(rx_q.pop_front()));
                end else begin
                    check("rx_empty_on_pop", 32'(bus.rx_empty), 32'd1);
                end
            end
        end
    end

    task automatic push_tx(input logic [7:0] d);
        bus.tx_wr_en   = 1'b1;
        bus.tx_wr_data = d;
        if (tx_q.size() < DEPTH) tx_q.push_back(d);
        tick();
        bus.tx_wr_en = 1'b0;
    endtask

    task automatic pop_rx(input int n);
        for (int i = 0; i < n; i++) begin
            bus.rx_rd_en = 1'b1;
            tick();
        end
        bus.rx_rd_en = 1'b0;
    endtask

    task automatic check_tx_level(input string tag);
        check({tag, "_tx_count"}, 32'(bus.tx_count), 32'(tx_q.size()));
        check({tag, "_tx_full"}, 32'(bus.tx_full), 32'(tx_q.size() == DEPTH));
    endtask

    task automatic check_reset_outputs();
        check("rst_tx_full", 32'(bus.tx_full), 32'd0);
        check("rst_tx_count", 32'(bus.tx_count), 32'd0);
        check("rst_cmd_err", 32'(bus.cmd_err), 32'd0);
        check("rst_burst_busy", 32'(bus.burst_busy), 32'd0);
        check("rst_burst_done", 32'(bus.burst_done), 32'd0);
        check("rst_rx_rd_data", 32'(bus.rx_rd_data), 32'd0);
        check("rst_rx_empty", 32'(bus.rx_empty), 32'd1);
        check("rst_rx_overflow", 32'(bus.rx_overflow), 32'd0);
        check("rst_ctl_start", 32'(bus.ctl_start), 32'd0);
        check("rst_ctl_data", 32'(bus.ctl_data), 32'd0);
        check("rst_ctl_hold_cs", 32'(bus.ctl_hold_cs), 32'd0);
    endtask

    // Model update plus a one-cycle command strobe; returns whether it should run.
    task automatic issue_cmd(input int len, output bit legal);
        legal = (len >= 1) && (len <= DEPTH) && (tx_q.size() >= len);
        if (legal) begin
            for (int i = 0; i < len; i++) begin
                logic [7:0] b;
                b = tx_q.pop_front();
                exp_tx_q.push_back(b);
                exp_hold_q.push_back((len - i) > 1);
                if (rx_q.size() < DEPTH) rx_q.push_back(b);
                else ovf_m = 1'b1;
            end
            exp_done_issued++;
            exp_starts++;
        end else begin
            exp_err_q.push_back(cyc + 1);
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = LW'(len);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input int len, input bit traffic);
        bit legal;
        bit ended;
        logic [7:0] d;
        issue_cmd(len, legal);
        if (legal) begin
            ended = 1'b0;
            for (int i = 0; i < 400 && !ended; i++) begin
                tick();
                bus.tx_wr_en  = 1'b0;
                bus.cmd_valid = 1'b0;
                if (!bus.burst_busy) begin
                    ended = 1'b1;
                end else if (traffic) begin
                    if ($urandom_range(0, 3) == 0 && (tx_q.size() + len) < DEPTH) begin
                        d = 8'($urandom);
                        bus.tx_wr_en   = 1'b1;
                        bus.tx_wr_data = d;
                        tx_q.push_back(d);
                    end else if ($urandom_range(0, 5) == 0) begin
                        bus.cmd_valid = 1'b1;
                        bus.cmd_len   = LW'($urandom_range(0, 15));
                    end
                end
            end
            bus.tx_wr_en  = 1'b0;
            bus.cmd_valid = 1'b0;
            check("burst_finished", 32'(ended), 32'd1);
        end else begin
            tick();
            tick();
            check("stay_idle_after_err", 32'(bus.burst_busy), 32'd0);
        end
        check("rx_overflow", 32'(bus.rx_overflow), 32'(ovf_m));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit legal;
        int base;
        int len;
        rst            = 1'b0;
        bus.tx_wr_en   = 1'b0;
        bus.tx_wr_data = 8'h00;
        bus.cmd_valid  = 1'b0;
        bus.cmd_len    = '0;
        bus.rx_rd_en   = 1'b0;
        repeat (3) tick();
        check_reset_outputs();
        rst = 1'b1;
        tick();

        // Three-byte loop-back burst.
        push_tx(8'hA5);
        push_tx(8'h3C);
        push_tx(8'hF0);
        check_tx_level("pre_burst3");
        run_cmd(3, 1'b0);
        check("single_start", 32'(n_start), 32'd1);
        check("single_done", 32'(done_seen), 32'd1);
        check_tx_level("post_burst3");
        pop_rx(3);
        check("rx_drained", 32'(bus.rx_empty), 32'd1);

        // Rejected commands: too few bytes, zero length, over depth.
        push_tx(8'h11);
        push_tx(8'h22);
        run_cmd(3, 1'b0);
        check_tx_level("after_short_cmd");
        run_cmd(0, 1'b0);
        run_cmd(DEPTH + 1, 1'b0);
        check("no_start_on_err", 32'(n_start), 32'd1);
        run_cmd(2, 1'b0);
        pop_rx(2);

        // Fill TX, drop the extra byte, send the full depth.
        for (int i = 0; i < DEPTH; i++) push_tx(8'($urandom));
        push_tx(8'hEE);
        check_tx_level("tx_full");
        run_cmd(DEPTH, 1'b0);
        check_tx_level("after_full_burst");

        // RX is now full: one more byte must be dropped.
        push_tx(8'h5A);
        run_cmd(1, 1'b0);
        check("rx_overflow_set", 32'(bus.rx_overflow), 32'd1);
        pop_rx(rx_q.size());
        pop_rx(1);

        // Reset in the middle of a four-byte burst.
        for (int i = 0; i < 4; i++) push_tx(8'($urandom));
        base = n_bytes;
        issue_cmd(4, legal);
        for (int i = 0; i < 200 && n_bytes < base + 2; i++) @(negedge clk);
        check("two_bytes_before_reset", 32'(n_bytes >= base + 2), 32'd1);
        tick();
        rst       = 1'b0;
        ctl_abort = 1'b1;
        tick();
        check_reset_outputs();
        rst = 1'b1;
        tx_q.delete();
        rx_q.delete();
        exp_tx_q.delete();
        exp_hold_q.delete();
        ovf_m = 1'b0;
        exp_done_issued--;
        tick();
        tick();
        ctl_abort = 1'b0;
        tick();
        push_tx(8'hC3);
        run_cmd(1, 1'b0);
        pop_rx(1);
        check("rx_empty_after_fresh", 32'(bus.rx_empty), 32'd1);

        // Randomized traffic.
        for (int it = 0; it < 40; it++) begin
            int k;
            k = int'($urandom_range(0, 5));
            for (int j = 0; j < k; j++) push_tx(8'($urandom));
            check_tx_level("rand_idle");
            pop_rx(int'($urandom_range(0, 3)));
            if ($urandom_range(0, 9) < 7) begin
                len = int'($urandom_range(1, (tx_q.size() > 0) ? tx_q.size() : 1));
            end else begin
                len = int'($urandom_range(0, 15));
            end
            run_cmd(len, 1'b1);
        end

        pop_rx(rx_q.size());
        pop_rx(1);
        repeat (3) tick();
        check("end_rx_model_empty", 32'(rx_q.size()), 32'd0);
        check("end_tx_bytes_sent", 32'(exp_tx_q.size()), 32'd0);
        check("end_cmd_err_pending", 32'(exp_err_q.size()), 32'd0);
        check("end_burst_done_count", 32'(done_seen), 32'(exp_done_issued));
        check("end_start_count", 32'(n_start), 32'(exp_starts));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
